// File: rtl/dot_update_queue_if.sv
// Dot-update bus: processor write strobe in, single-entry handshake out to the VGA store.
interface dot_update_queue_if #(
    parameter int unsigned ID_W  = 9,
    parameter int unsigned LOC_W = 10
);
    logic             wr_en;
    logic             wr_is_y;
    logic [ID_W-1:0]  wr_id;
    logic [LOC_W-1:0] wr_loc;

    logic             upd_valid;
    logic             upd_ready;
    logic             upd_is_y;
    logic [ID_W-1:0]  upd_id;
    logic [LOC_W-1:0] upd_loc;

    modport master (
        output wr_en, wr_is_y, wr_id, wr_loc, upd_ready,
        input  upd_valid, upd_is_y, upd_id, upd_loc
    );

    modport slave (
        input  wr_en, wr_is_y, wr_id, wr_loc, upd_ready,
        output upd_valid, upd_is_y, upd_id, upd_loc
    );
endinterface

// File: rtl/dot_update_queue.sv
// FWFT queue of processor dot-location writes toward the VGA dot store.
// Optional DOT_VBLANK_GATE_EN holds delivery until vertical blanking.
module dot_update_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ID_W     = 9,
    parameter int unsigned LOC_W    = 10,
    parameter int unsigned NUM_DOTS = 450
) (
    input  logic                   clock_100,
    input  logic                   reset,
    input  logic                   proc_clk,
    input  logic                   vblank,
    input  logic                   clr_flags,
    dot_update_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   range_err,
    output logic [7:0]             drop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             is_y;
        logic [ID_W-1:0]  id;
        logic [LOC_W-1:0] loc;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_proc_clk_d;
    logic             r_overflow;
    logic             r_range_err;
    logic [7:0]       r_drop_cnt;

    logic   w_capture;
    logic   w_push_req;
    logic   w_id_bad;
    logic   w_full;
    logic   w_empty;
    logic   w_gate;
    logic   w_pop;
    logic   w_push;
    logic   w_drop_range;
    logic   w_drop_full;
    entry_t w_wr_entry;
    entry_t w_head;

`ifdef DOT_VBLANK_GATE_EN
    logic r_vblank_q;

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) r_vblank_q <= 1'b0;
        else       r_vblank_q <= vblank;
    end

    assign w_gate = r_vblank_q;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_gate          = 1'b1;
`endif

    // Falling edge of the processor clock: mid-cycle, inputs are stable.
    assign w_capture  = r_proc_clk_d & ~proc_clk;
    assign w_push_req = w_capture & bus.wr_en;
    assign w_id_bad   = 32'(bus.wr_id) >= NUM_DOTS;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_pop        = bus.upd_valid & bus.upd_ready;
    assign w_push       = w_push_req & ~w_id_bad & (~w_full | w_pop);
    assign w_drop_range = w_push_req & w_id_bad;
    assign w_drop_full  = w_push_req & ~w_id_bad & w_full & ~w_pop;

    assign w_wr_entry = '{is_y: bus.wr_is_y, id: bus.wr_id, loc: bus.wr_loc};
    assign w_head     = r_mem[r_rd_ptr];

    assign bus.upd_valid = ~w_empty & w_gate;
    assign bus.upd_is_y  = w_head.is_y;
    assign bus.upd_id    = w_head.id;
    assign bus.upd_loc   = w_head.loc;

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign range_err = r_range_err;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) r_proc_clk_d <= 1'b1;
        else       r_proc_clk_d <= proc_clk;
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clock_100) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Clear beats a coincident drop.
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (clr_flags) begin
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_drop_full)  r_overflow  <= 1'b1;
            if (w_drop_range) r_range_err <= 1'b1;
            if ((w_drop_full || w_drop_range) && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
endmodule
